shared_reg_arbiter: RTL and testbench

//  Round-robin arbiter and write sequencer for one shared WIDTH-bit D-register (posedge CLK).

---
 rtl/shared_reg_arbiter.sv | 131 +++++++++++++
 tb/tb_shared_reg_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner arbitration and write sequencing for one shared WIDTH-bit register; SHARED_REG_TIMEOUT_EN adds a forced release after MAX_HOLD cycles.
// Latency: REQ sampled in IDLE/GAP gives GNT the next cycle; an owner write reaches Q one cycle after WE.
// Backpressure: requesters hold REQ until granted; an owner frees the port with DONE or by dropping REQ.
module shared_reg_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NREQ-1:0]          REQ,
  input  logic [NREQ-1:0]          WE,
  input  logic [NREQ*WIDTH-1:0]    WDATA,
  input  logic [NREQ-1:0]          DONE,
  output logic [NREQ-1:0]          GNT,
  output logic [$clog2(NREQ)-1:0]  GNT_ID,
  output logic                     BUSY,
  output logic [WIDTH-1:0]         Q,
  output logic                     TIMEOUT
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_last;

  logic             win_vld;
  logic [IDW-1:0]   win_id;
  logic [IDW:0]     cand;

  logic             owner_we;
  logic             owner_done;
  logic             owner_req;
  logic [WIDTH-1:0] owner_wdata;
  logic             release_vol;
  logic             hold_expired;

  // Candidates are visited starting one past the previous winner, wrapping at NREQ.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, rr_last} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ))
        cand = cand - (IDW+1)'(NREQ);
      if (!win_vld && REQ[cand[IDW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = cand[IDW-1:0];
      end
    end
  end

  // GNT_ID is the owner while in GRANT, so it selects the owner's controls.
  always_comb begin
    owner_we    = 1'b0;
    owner_done  = 1'b0;
    owner_req   = 1'b0;
    owner_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GNT_ID == IDW'(i)) begin
        owner_we    = WE[i];
        owner_done  = DONE[i];
        owner_req   = REQ[i];
        owner_wdata = WDATA[i*WIDTH +: WIDTH];
      end
    end
  end

  assign release_vol = owner_done | ~owner_req;

`ifdef SHARED_REG_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);

  logic [HCW-1:0] hold_cnt;

  // hold_cnt counts completed GRANT cycles; the MAX_HOLD-th one forces release.
  assign hold_expired = (state == S_GRANT) && (hold_cnt == HCW'(MAX_HOLD - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      hold_cnt <= '0;
    else if (state != S_GRANT)
      hold_cnt <= '0;
    else
      hold_cnt <= hold_cnt + 1'b1;
  end
`else
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      GNT     <= '0;
      GNT_ID  <= '0;
      BUSY    <= 1'b0;
      Q       <= '0;
      TIMEOUT <= 1'b0;
      rr_last <= IDW'(NREQ - 1);
    end else begin
      TIMEOUT <= 1'b0;
      case (state)
        S_GRANT: begin
          if (owner_we)
            Q <= owner_wdata;
          if (release_vol || hold_expired) begin
            state   <= S_GAP;
            GNT     <= '0;
            BUSY    <= 1'b0;
            TIMEOUT <= hold_expired & ~release_vol;
          end
        end
        default: begin
          if (win_vld) begin
            state   <= S_GRANT;
            GNT     <= {{(NREQ-1){1'b0}}, 1'b1} << win_id;
            GNT_ID  <= win_id;
            rr_last <= win_id;
            BUSY    <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboarded bench for shared_reg_arbiter: directed scenarios followed by random traffic.
module tb_shared_reg_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int MAXH  = 4;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  REQ   = '0;
  logic [3:0]  WE    = '0;
  logic [3:0]  DONE  = '0;
  logic [31:0] WDATA = '0;
  logic [3:0]  GNT;
  logic [1:0]  GNT_ID;
  logic        BUSY;
  logic [7:0]  Q;
  logic        TIMEOUT;

  always #5 CLK = ~CLK;

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAXH)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .WDATA(WDATA), .DONE(DONE),
    .GNT(GNT), .GNT_ID(GNT_ID), .BUSY(BUSY), .Q(Q), .TIMEOUT(TIMEOUT)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic [7:0] q;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: owner index (-1 = nobody), round-robin pointer, cycles held.
  int         m_owner = -1;
  int         m_rr    = NREQ - 1;
  int         m_last  = 0;
  int         m_held  = 0;
  logic [7:0] m_q     = '0;
  logic       m_to    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic logic [31:0] sl(input int idx, input logic [7:0] v);
    return {24'd0, v} << (idx * 8);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rr = NREQ - 1; m_last = 0; m_held = 0; m_q = '0; m_to = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] w, input logic [3:0] d,
                            input logic [31:0] wd);
    bit vol, forced;
    if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_rr + k) % NREQ;
        if (m_owner < 0 && ((r >> c) & 4'd1) != 4'd0) begin
          m_owner = c; m_rr = c; m_last = c; m_held = 0;
        end
      end
    end else begin
      if (((w >> m_owner) & 4'd1) != 4'd0) m_q = 8'(wd >> (m_owner * 8));
      m_held++;
      vol    = ((d >> m_owner) & 4'd1) != 4'd0 || ((r >> m_owner) & 4'd1) == 4'd0;
      forced = 1'b0;
`ifdef SHARED_REG_TIMEOUT_EN
      forced = (m_held >= MAXH) && !vol;
`endif
      m_to = forced;
      if (vol || forced) m_owner = -1;
    end
    exp_q.push_back('{gnt: (m_owner < 0) ? 4'd0 : 4'(1 << m_owner), id: 2'(m_last),
                      busy: (m_owner >= 0), q: m_q, to: m_to});
  endtask

  // Monitor: every expected cycle is compared one half-period after its edge.
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("sb_gnt",     32'(GNT),     32'(mon_e.gnt));
      chk("sb_gnt_id",  32'(GNT_ID),  32'(mon_e.id));
      chk("sb_busy",    32'(BUSY),    32'(mon_e.busy));
      chk("sb_q",       32'(Q),       32'(mon_e.q));
      chk("sb_timeout", 32'(TIMEOUT), 32'(mon_e.to));
    end
  end

  task automatic cyc(input logic [3:0] r, input logic [3:0] w, input logic [3:0] d,
                     input logic [31:0] wd);
    @(negedge CLK);
    REQ = r; WE = w; DONE = d; WDATA = wd;
    @(posedge CLK);
    model_step(r, w, d, wd);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    RST_N = 1'b0; REQ = '0; WE = '0; DONE = '0; WDATA = '0;
    model_reset();
    #1;
    chk("rst_gnt",     32'(GNT),     32'd0);
    chk("rst_q",       32'(Q),       32'd0);
    chk("rst_busy",    32'(BUSY),    32'd0);
    chk("rst_gnt_id",  32'(GNT_ID),  32'd0);
    chk("rst_timeout", 32'(TIMEOUT), 32'd0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
  endtask

  logic [3:0] seq[9];
  logic [3:0] exp2[9];
  logic [3:0] g6[8];
  logic       t6[8];
  logic [3:0] rr_r;
  int         run3;
  bit         in_run, to_seen;

  initial begin
    do_reset();

    // Single requester writes through its grant.
    cyc(4'b0100, 4'b0100, 4'b0000, sl(2, 8'hA5));
    chk("t1_gnt",    32'(GNT),    32'h4);
    chk("t1_gnt_id", 32'(GNT_ID), 32'd2);
    cyc(4'b0100, 4'b0100, 4'b0000, sl(2, 8'hA5));
    chk("t1_q",      32'(Q),      32'hA5);
    cyc(4'b0000, 4'b0000, 4'b0000, 32'd0);
    cyc(4'b0000, 4'b0000, 4'b0000, 32'd0);

    // Full contention, each owner releases immediately.
    do_reset();
    exp2 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    for (int i = 0; i < 9; i++) begin
      cyc(4'b1111, 4'b0000, 4'b1111, 32'd0);
      seq[i] = GNT;
    end
    for (int i = 0; i < 9; i++) chk($sformatf("t2_order[%0d]", i), 32'(seq[i]), 32'(exp2[i]));
    cyc(4'b0000, 4'b0000, 4'b0000, 32'd0);
    cyc(4'b0000, 4'b0000, 4'b0000, 32'd0);

    // Non-owner write is ignored.
    cyc(4'b0001, 4'b0000, 4'b0000, 32'd0);
    cyc(4'b0001, 4'b0001, 4'b0000, sl(0, 8'h3C));
    cyc(4'b0011, 4'b0010, 4'b0010, sl(1, 8'hFF));
    chk("t3_q",   32'(Q),   32'h3C);
    chk("t3_gnt", 32'(GNT), 32'h1);
    cyc(4'b0000, 4'b0000, 4'b0000, 32'd0);
    cyc(4'b0000, 4'b0000, 4'b0000, 32'd0);

    // DONE with a concurrent write.
    cyc(4'b0010, 4'b0000, 4'b0000, 32'd0);
    cyc(4'b0010, 4'b0010, 4'b0010, sl(1, 8'h5A));
    chk("t4_q",    32'(Q),    32'h5A);
    chk("t4_gnt",  32'(GNT),  32'h0);
    chk("t4_busy", 32'(BUSY), 32'd0);
    cyc(4'b0000, 4'b0000, 4'b0000, 32'd0);

    // Asynchronous reset in the middle of a grant.
    cyc(4'b0100, 4'b0000, 4'b0000, 32'd0);
    cyc(4'b0100, 4'b0100, 4'b0000, sl(2, 8'h77));
    chk("t5_q_before", 32'(Q), 32'h77);
    do_reset();
    cyc(4'b1111, 4'b0000, 4'b0000, 32'd0);
    chk("t5_first_winner", 32'(GNT), 32'h1);
    cyc(4'b0000, 4'b0000, 4'b0000, 32'd0);
    cyc(4'b0000, 4'b0000, 4'b0000, 32'd0);

    // Requester 3 never releases while requester 0 waits.
    run3 = 0; in_run = 1'b1; to_seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cyc((i == 0) ? 4'b1000 : 4'b1001, 4'b0000, 4'b0000, 32'd0);
      if (in_run && GNT == 4'b1000) run3++;
      else in_run = 1'b0;
      if (TIMEOUT) to_seen = 1'b1;
      if (i < 8) begin g6[i] = GNT; t6[i] = TIMEOUT; end
    end
`ifdef SHARED_REG_TIMEOUT_EN
    chk("t6_hold_cycles", 32'(run3), 32'(MAXH));
    chk("t6_gap_gnt",     32'(g6[MAXH]), 32'h0);
    chk("t6_gap_timeout", 32'(t6[MAXH]), 32'd1);
    chk("t6_next_owner",  32'(g6[MAXH+1]), 32'h1);
    chk("t6_to_prev",     32'(t6[MAXH-1]), 32'd0);
`else
    chk("t6_hold_cycles", 32'(run3), 32'd24);
    chk("t6_timeout_seen", 32'(to_seen), 32'd0);
`endif
    cyc(4'b0000, 4'b0000, 4'b0000, 32'd0);
    cyc(4'b0000, 4'b0000, 4'b0000, 32'd0);

    // Random traffic with sticky requests and occasional DONE.
    rr_r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rr_r = 4'($urandom);
      cyc(rr_r, 4'($urandom), ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000, $urandom);
    end

    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
